// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared states, default sizes and select-width helper for the mux scan sequencer
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t;
  localparam int WIDTH_DEF = 4;
  localparam int NCH_DEF = 4;
  localparam int SETTLE_DEF = 2;
  function automatic int clog2_min1(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: sample output port (out_valid/out_ready/out_data/out_chan) plus scan_done pulse
interface mux_scan_sequencer_if
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CH_W = clog2_min1(NCH_DEF)
);
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0] out_chan;
  logic scan_done;
  modport master(output out_valid, out_data, out_chan, scan_done, input out_ready);
  modport slave(input out_valid, out_data, out_chan, scan_done, output out_ready);
endinterface

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: first set ch_mask bit after cur with wrap; cur=NCH-1 yields the lowest set bit
module mux_scan_next_ch
  import mux_scan_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CH_W = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  ch_mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] nxt,
  output logic            wrapped
);
  int best;
  always_comb begin
    nxt = cur;
    best = NCH;
    for (int j = 0; j < NCH; j++) begin
      if (ch_mask[j] && ((j - int'(cur) - 1 + 2 * NCH) % NCH) < best) begin
        best = (j - int'(cur) - 1 + 2 * NCH) % NCH;
        nxt = CH_W'(j);
      end
    end
    wrapped = |ch_mask && nxt <= cur;
  end
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: round-robin mux select scanner emitting (chan,data) samples; MUX_SCAN_CHANGE_ONLY_EN suppresses unchanged samples
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH = NCH_DEF,
  parameter int SETTLE = SETTLE_DEF,
  localparam int CH_W = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       ch_mask,
  output logic [CH_W-1:0]      sel,
  input  logic [WIDTH-1:0]     y,
  mux_scan_sequencer_if.master o
);
  scan_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [CH_W-1:0] sel_n, chan_q, chan_n, cur, nxt;
  logic [WIDTH-1:0] data_q, data_n;
  logic valid_q, valid_n, done_q, done_n, wrapped, skip, capture, advance;
  assign cur = state == IDLE ? CH_W'(NCH - 1) : sel;
  mux_scan_next_ch #(.NCH(NCH), .CH_W(CH_W)) u_next (
    .ch_mask(ch_mask),
    .cur(cur),
    .nxt(nxt),
    .wrapped(wrapped)
  );
  assign capture = state == mux_scan_pkg::SETTLE && cnt == '0;
`ifdef MUX_SCAN_CHANGE_ONLY_EN
  logic [WIDTH-1:0] last [NCH];
  logic [NCH-1:0] seen;
  assign skip = seen[sel] && y == last[sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      seen <= '0;
      for (int i = 0; i < NCH; i++) last[i] <= '0;
    end else if (capture && !skip) begin
      seen[sel] <= 1'b1;
      last[sel] <= y;
    end
  end
`else
  assign skip = 1'b0;
`endif
  assign advance = (state == HOLD && valid_q && o.out_ready) || (capture && skip);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = sel;
    valid_n = valid_q;
    data_n = data_q;
    chan_n = chan_q;
    done_n = 1'b0;
    if (state == IDLE && en && |ch_mask) begin
      sel_n = nxt;
      cnt_n = 4'(SETTLE - 1);
      state_n = mux_scan_pkg::SETTLE;
    end else if (state == mux_scan_pkg::SETTLE && cnt != '0) begin
      cnt_n = cnt - 4'd1;
    end else if (capture && !skip) begin
      data_n = y;
      chan_n = sel;
      valid_n = 1'b1;
      state_n = HOLD;
    end
    if (advance) begin
      valid_n = 1'b0;
      done_n = wrapped;
      sel_n = en && |ch_mask ? nxt : sel;
      cnt_n = en && |ch_mask ? 4'(SETTLE - 1) : cnt;
      state_n = en && |ch_mask ? mux_scan_pkg::SETTLE : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sel <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel <= sel_n;
      valid_q <= valid_n;
      data_q <= data_n;
      chan_q <= chan_n;
      done_q <= done_n;
    end
  end
  assign o.out_valid = valid_q;
  assign o.out_data = data_q;
  assign o.out_chan = chan_q;
  assign o.scan_done = done_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: randomized scoreboard bench for mux_scan_sequencer with a list-based scan model
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;
  typedef struct {
    logic [1:0] chan;
    logic [3:0] data;
    bit wrap;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [1:0] sel;
  logic [3:0] y;
  logic [3:0] mux_in [4];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int phase = 0;
  int last_phase = -1;
  int last_cyc = 0;
  int ready_mode = 0;
  exp_t q[$];
  bit exp_done = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev = '0;
  mux_scan_sequencer_if #(.WIDTH(4), .CH_W(2)) bus();
  mux_scan_sequencer #(.WIDTH(4), .NCH(4), .SETTLE(2)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .ch_mask(ch_mask),
    .sel(sel),
    .y(y),
    .o(bus)
  );
  assign y = mux_in[sel];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    bus.out_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom % 3 != 0);
  end
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_hold = 1'b0;
      exp_done = 1'b0;
    end else begin
      chk("scan_done", 8'(bus.scan_done), 8'(exp_done));
      if (bus.out_valid) chk("sel_vs_chan", 8'(sel), 8'(bus.out_chan));
      if (prev_hold) chk("hold_stable", {2'b00, bus.out_valid, bus.out_chan, bus.out_data}, prev);
      prev_hold = bus.out_valid && !bus.out_ready;
      prev = {2'b00, 1'b1, bus.out_chan, bus.out_data};
      exp_done = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got chan %0d data %b, no sample expected", bus.out_chan, bus.out_data);
        end else begin
          e = q.pop_front();
          chk("out_chan", 8'(bus.out_chan), 8'(e.chan));
          chk("out_data", 8'(bus.out_data), 8'(e.data));
          exp_done = e.wrap;
          if (ready_mode == 1 && last_phase == phase) chk("spacing", 8'(cyc - last_cyc), 8'd3);
        end
        last_phase = phase;
        last_cyc = cyc;
      end
    end
  end
  task automatic run_phase(input logic [3:0] m, input int n, input int mode);
    int lst[$];
    int t;
    exp_t e;
    for (int c = 0; c < 4; c++) if (m[c]) lst.push_back(c);
    for (int k = 0; k < n; k++) begin
      e.chan = 2'(lst[k % lst.size()]);
      e.data = mux_in[lst[k % lst.size()]];
      e.wrap = (k % lst.size()) == lst.size() - 1;
      q.push_back(e);
    end
    ready_mode = mode;
    phase++;
    ch_mask = m;
    en = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (hs_cnt < hs_cnt_base_of(n) && t < 2000);
    #1 en = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout: %0d samples outstanding, required 0", q.size());
      q.delete();
    end
    repeat (6) @(negedge clk) chk("idle_no_valid", 8'(bus.out_valid), 8'd0);
  endtask
  int base_hs = 0;
  function automatic int hs_cnt_base_of(input int n);
    return base_hs + n - 1;
  endfunction
  initial begin
    int t;
    mux_in = '{4'b0101, 4'b1001, 4'b0011, 4'b0001};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_out_data", 8'(bus.out_data), 8'd0);
    chk("rst_out_chan", 8'(bus.out_chan), 8'd0);
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_scan_done", 8'(bus.scan_done), 8'd0);
    rst = 1'b0;
    base_hs = hs_cnt;
    run_phase(4'b1111, 8, 1);
    base_hs = hs_cnt;
    run_phase(4'b1010, 4, 1);
    base_hs = hs_cnt;
    run_phase(4'b0100, 3, 0);
    base_hs = hs_cnt;
    run_phase(4'b1111, 5, 0);
    repeat (12) begin
      for (int c = 0; c < 4; c++) mux_in[c] = 4'($urandom);
      base_hs = hs_cnt;
      run_phase(4'($urandom_range(1, 15)), $urandom_range(1, 7), $urandom_range(0, 1));
    end
    ready_mode = 2;
    ch_mask = 4'b1111;
    en = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_hold", 8'(bus.out_valid), 8'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_hold_sel", 8'(sel), 8'd0);
    chk("rst_hold_done", 8'(bus.scan_done), 8'd0);
    rst = 1'b0;
    en = 1'b0;
    repeat (4) @(negedge clk) chk("rst_idle_valid", 8'(bus.out_valid), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 4-bit 4:1 mux stage (mux_4bits).
- Drives the mux select and steps round-robin through the enabled channels.
- Waits a settle time after each select change, then captures the mux output y.
- Presents each capture as a (channel, data) sample on a valid/ready output port for downstream logging.

Parameters:
- WIDTH, 4, data width of mux inputs/output y and out_data.
- NCH, 4, number of mux channels; sel width CH_W = $clog2(NCH).
- SETTLE, 2, cycles between a sel change and the capture of y; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; level-sensitive.
- ch_mask  input  NCH  channel enable mask; bit i=1 means channel i is scanned.
- sel  output  CH_W  select to the mux; registered.
- y  input  WIDTH  mux output, combinational from the mux.
- out_valid  output  1  sample available.
- out_ready  input  1  downstream accepts sample.
- out_data  output  WIDTH  captured y.
- out_chan  output  CH_W  channel the sample came from.
- scan_done  output  1  one-cycle pulse when a pass over all enabled channels completes.

Behaviour:
- One clock. Reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values: sel=0, out_valid=0, out_data=0, out_chan=0, scan_done=0, state=IDLE, settle counter=0.
- rst asserted mid-scan aborts immediately: any pending sample is dropped and the block returns to IDLE.
- State machine, three states:
  - IDLE:
    - If en=1 and ch_mask!=0 at edge k, set sel = lowest set bit of ch_mask, cnt = SETTLE-1, go to SETTLE.
    - Otherwise stay in IDLE.
  - SETTLE:
    - If cnt!=0, decrement cnt.
    - If cnt==0: out_data<=y, out_chan<=sel, out_valid<=1, go to HOLD.
    - out_valid is first high in cycle k+1+SETTLE.
    - ch_mask and en are ignored in this state.
  - HOLD:
    - out_valid, out_data and out_chan are held stable until out_valid&&out_ready.
    - On the handshake edge:
      - out_valid<=0.
      - nxt = first set bit of ch_mask searching sel+1, sel+2, ..., with wrap modulo NCH.
      - scan_done<=1 for one cycle if nxt<=sel (wrapped), including the single-channel case nxt==sel.
      - If en=1 and ch_mask!=0: sel<=nxt, cnt<=SETTLE-1, go to SETTLE.
      - Otherwise go to IDLE with sel unchanged.
- Back-to-back: the minimum spacing between samples is SETTLE+1 cycles when out_ready is tied high.
- out_ready while out_valid=0 is ignored.
- Dropping en does not truncate an outstanding sample; the HOLD handshake still completes.

Optional Feature:
- Macro: MUX_SCAN_CHANGE_ONLY_EN.
- Defined:
  - Per-channel last-emitted value register plus seen flag, both cleared on rst.
  - On the SETTLE capture, if seen[sel]=1 and y==last[sel], no sample is produced (out_valid stays 0).
  - In that skip case the block advances exactly as in a HOLD handshake on the same edge, including scan_done on wrap.
  - When a sample is emitted, last[sel]<=y and seen[sel]<=1.
- Undefined: every capture is emitted; no per-channel storage is synthesised.

Decomposition:
- Package mux_scan_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t.
  - Default constants WIDTH_DEF=4, NCH_DEF=4, SETTLE_DEF=2.
  - Function clog2_min1.
- One sub-module: mux_scan_next_ch.
  - Combinational wrap-around priority finder.
  - Inputs ch_mask and cur; outputs nxt and wrapped.
  - Also reused for the IDLE lowest-set-bit search via cur=NCH-1.

Test Plan:
- Full scan, mux_4bits with a=0101, b=1001, c=0011, d=0001, ch_mask=1111, en=1, out_ready=1:
  - samples (chan,data) = (0,0101), (1,1001), (2,0011), (3,0001);
  - scan_done pulses after chan 3;
  - sample spacing = 3 cycles.
- Sparse mask ch_mask=1010:
  - sel sequence 1,3,1,3; data 1001, 0001, ...;
  - scan_done after every chan-3 sample.
- Backpressure: out_ready=0 for 5 cycles at the first sample:
  - out_valid=1 and (0,0101) held stable;
  - sel stays 0;
  - the next sample comes SETTLE+1 cycles after out_ready rises.
- Single channel ch_mask=0100:
  - every sample is (2,0011);
  - scan_done pulses on every handshake.
- en dropped during SETTLE of chan 1:
  - the chan-1 sample is still emitted;
  - then IDLE, no further out_valid.
- rst during HOLD:
  - next cycle out_valid=0, sel=0, scan_done=0, state IDLE.
- Also with MUX_SCAN_CHANGE_ONLY_EN defined, y constant over two full scans:
  - only 4 samples are emitted;
  - scan_done still pulses twice.
